shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 105 ++++++++++
 tb/tb_shift_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Variable-amount left shift/rotate sequencer: steps a per-nibble slice chain
// one bit per clock between a request and a result valid/ready handshake.
module shift_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AMT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_rot,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_carry,
  output logic              busy
);

  localparam int unsigned NSLICE = DATA_W / 4;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_step;
  logic [AMT_W-1:0]  count;
  logic              carry;
  logic              mode;
  logic [NSLICE-1:0] slice_fill;

  // Each 4-bit slice takes its fill from the MSB of the slice below; only the
  // lowest slice's fill is chosen by the controller (rotate or zero).
  always_comb begin
    slice_fill    = '0;
    data_step     = '0;
    slice_fill[0] = mode & data_q[DATA_W-1];
    for (int unsigned k = 1; k < NSLICE; k++) begin
      slice_fill[k] = data_q[4*k-1];
    end
    for (int unsigned k = 0; k < NSLICE; k++) begin
      data_step[4*k +: 4] = {data_q[4*k +: 3], slice_fill[k]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_q    <= '0;
      count     <= '0;
      carry     <= 1'b0;
      mode      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            count    <= in_amt;
            mode     <= in_rot;
            carry    <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (in_amt == '0) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q <= data_step;
          carry  <= data_q[DATA_W-1];
          count  <= count - 1'b1;
          if (count == AMT_W'(1)) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_data  = data_q;
  assign out_carry = carry;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus random requests
// checked against an arithmetic shift/rotate reference model.
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic        in_rot;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_carry;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  shift_sequencer #(.DATA_W(16), .AMT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_rot    (in_rot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: a left shift by n in a wide word; the bits above 16 are what
  // fell off the top, bit 16 being the last one shifted out.
  function automatic logic [16:0] model(input logic [15:0] d, input int n, input logic rot);
    logic [31:0] ext;
    logic [15:0] res;
    ext = {16'h0, d} << n;
    res = rot ? (ext[15:0] | ext[31:16]) : ext[15:0];
    return {(n == 0) ? 1'b0 : ext[16], res};
  endfunction

  task automatic run_op(input logic [15:0] d, input logic [3:0] amt, input logic rot,
                        input int hold_cycles);
    logic [16:0] exp;
    int          cyc;
    exp = model(d, int'(amt), rot);
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check("in_ready_before_req", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = amt;
    in_rot   = rot;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_amt   = 4'($urandom);
    in_rot   = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      check("busy_during_shift", {31'h0, busy}, 32'h1);
      check("in_ready_during_shift", {31'h0, in_ready}, 32'h0);
      @(posedge clk); #1; cyc++;
    end
    check("latency", cyc, int'(amt));
    check("out_valid", {31'h0, out_valid}, 32'h1);
    check("out_data", {16'h0, out_data}, {16'h0, exp[15:0]});
    check("out_carry", {31'h0, out_carry}, {31'h0, exp[16]});
    // Backpressure: hold the result while new requests are offered and ignored.
    for (int i = 0; i < hold_cycles; i++) begin
      in_valid = 1'($urandom);
      in_data  = $urandom;
      in_amt   = 4'($urandom);
      @(posedge clk); #1;
      check("hold_valid", {31'h0, out_valid}, 32'h1);
      check("hold_data", {16'h0, out_data}, {16'h0, exp[15:0]});
      check("hold_carry", {31'h0, out_carry}, {31'h0, exp[16]});
      check("hold_in_ready", {31'h0, in_ready}, 32'h0);
      check("hold_busy", {31'h0, busy}, 32'h1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_out_valid", {31'h0, out_valid}, 32'h0);
    check("post_hs_in_ready", {31'h0, in_ready}, 32'h1);
    check("post_hs_busy", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    logic seen_valid;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_rot    = 1'b0;
    out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", {16'h0, out_data}, 32'h0);
    check("rst_out_carry", {31'h0, out_carry}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases, including the exact values worked out by hand.
    check("dir_model_e198", {15'h0, model(16'hF0CC, 1, 1'b0)}, {15'h0, 1'b1, 16'hE198});
    run_op(16'hF0CC, 4'd1, 1'b0, 0);
    run_op(16'hAC22, 4'd0, 1'b0, 2);
    run_op(16'h8001, 4'd4, 1'b1, 0);
    run_op(16'h8001, 4'd1, 1'b1, 1);
    run_op(16'hFFFF, 4'd15, 1'b0, 0);
    run_op(16'h1234, 4'd7, 1'b0, 5);
    run_op(16'hFFFF, 4'd15, 1'b1, 0);

    // Reset during SHIFT: after three steps of an 8-step operation.
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    in_amt   = 4'd8;
    in_rot   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_out_data", {16'h0, out_data}, 32'h0);
    check("mid_rst_out_carry", {31'h0, out_carry}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen_valid = 1'b1;
    end
    check("no_result_after_abort", {31'h0, seen_valid}, 32'h0);

    // Random requests against the reference model.
    for (int i = 0; i < 30; i++) begin
      run_op(16'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
